score_lives: RTL

//  Downstream of the asteroid quads: consumes per-frame asteroid BCD points and ship-hit events.

---
 rtl/asteroids_pkg.sv | 8 +
 rtl/bcd_digit_add.sv | 15 +
 rtl/score_lives.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/asteroids_pkg.sv
// asteroids_pkg: shared types and constants for the asteroids score/lives datapath
package asteroids;
   typedef logic [3:0] bcd_t;
   typedef enum logic [1:0] {SL_IDLE, SL_ADD, SL_COMMIT} score_st_t;
   localparam int SCORE_DIGITS = 5;
   localparam int LIVES_INIT = 3;
   localparam int LIVES_MAX = 9;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: single BCD digit adder with carry, shared across digits by the serial score adder
module bcd_digit_add
   import asteroids::*;
(
   input  bcd_t a,
   input  bcd_t b,
   input  logic cin,
   output bcd_t sum,
   output logic cout
);
   logic [4:0] raw;
   assign raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
   assign cout = raw > 5'd9;
   assign sum  = cout ? raw[3:0] + 4'd6 : raw[3:0];
endmodule

// File: rtl/score_lives.sv
// score_lives: digit-serial BCD score keeper with lives, game_over and optional high score (SCORE_HIGH_SCORE_EN)
module score_lives
   import asteroids::*;
#(
   parameter int DIGITS      = SCORE_DIGITS,
   parameter int LIVES_INIT  = asteroids::LIVES_INIT,
   parameter int LIVES_MAX   = asteroids::LIVES_MAX,
   parameter int EXTRA_DIGIT = 4
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                game_begin,
   input  logic                game_continue,
   input  logic [10:0]         ast_points,
   input  logic                ship_hit,
   output logic [DIGITS*4-1:0] score_bcd,
   output logic [3:0]          lives,
   output logic                game_over,
   output logic                extra_life,
   output logic                busy,
   output logic                pts_overflow,
   output logic [DIGITS*4-1:0] high_score
);
   localparam int W  = DIGITS * 4;
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   score_st_t      st_q, st_d;
   logic [W-1:0]   score_q, score_d, work_q, work_d, add_q, add_d, pend_q, pend_d, pts_w;
   logic           pend_v_q, pend_v_d, carry_q, carry_d, award_q, award_d;
   logic           ovf_q, ovf_d, go_q, go_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [3:0]     lives_q, lives_d;
   logic           accept, hit, award_ok, dcout;
   bcd_t           dsum;
   assign pts_w = {{(W-12){1'b0}}, 1'b0, ast_points};
   bcd_digit_add u_add (
      .a   (work_q[{idx_q, 2'b00} +: 4]),
      .b   (add_q[{idx_q, 2'b00} +: 4]),
      .cin (carry_q),
      .sum (dsum),
      .cout(dcout)
   );
   // next state: point intake, serial add FSM, lives bookkeeping, game_begin override
   always_comb begin
      accept   = |ast_points && game_continue && !go_q;
      hit      = ship_hit && game_continue && !go_q && lives_q != 4'd0;
      award_ok = st_q == SL_COMMIT && award_q && lives_q < 4'(LIVES_MAX);
      st_d     = st_q;
      score_d  = score_q;
      work_d   = work_q;
      add_d    = add_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      award_d  = award_q;
      ovf_d    = ovf_q;
      go_d     = go_q;
      lives_d  = lives_q + {3'b0, award_ok} - {3'b0, hit};
      if (accept && pend_v_q) ovf_d = 1'b1;
      else if (accept && st_q != SL_IDLE) begin
         pend_d   = pts_w;
         pend_v_d = 1'b1;
      end
      unique case (st_q)
         SL_IDLE: if (pend_v_q || accept) begin
            add_d    = pend_v_q ? pend_q : pts_w;
            pend_v_d = 1'b0;
            idx_d    = '0;
            carry_d  = 1'b0;
            award_d  = 1'b0;
            st_d     = SL_ADD;
         end
         SL_ADD: begin
            work_d[{idx_q, 2'b00} +: 4] = dsum;
            carry_d = dcout;
            if (EXTRA_DIGIT > 0 && EXTRA_DIGIT < DIGITS && idx_q == IW'(EXTRA_DIGIT - 1) && dcout) award_d = 1'b1;
            idx_d = idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
            st_d  = idx_q == IW'(DIGITS - 1) ? SL_COMMIT : SL_ADD;
         end
         SL_COMMIT: begin
            score_d = work_q;
            st_d    = SL_IDLE;
         end
         default: st_d = SL_IDLE;
      endcase
      if (hit && !award_ok && lives_q == 4'd1) go_d = 1'b1;
      if (game_begin) begin
         st_d     = SL_IDLE;
         score_d  = '0;
         work_d   = '0;
         pend_v_d = 1'b0;
         idx_d    = '0;
         carry_d  = 1'b0;
         award_d  = 1'b0;
         ovf_d    = 1'b0;
         go_d     = 1'b0;
         lives_d  = 4'(LIVES_INIT);
      end
   end
   // state registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         st_q     <= SL_IDLE;
         score_q  <= '0;
         work_q   <= '0;
         add_q    <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         award_q  <= 1'b0;
         ovf_q    <= 1'b0;
         go_q     <= 1'b1;
         lives_q  <= 4'd0;
      end else begin
         st_q     <= st_d;
         score_q  <= score_d;
         work_q   <= work_d;
         add_q    <= add_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         award_q  <= award_d;
         ovf_q    <= ovf_d;
         go_q     <= go_d;
         lives_q  <= lives_d;
      end
   end
`ifdef SCORE_HIGH_SCORE_EN
   logic         go_prev_q;
   logic [W-1:0] hs_q;
   // capture the final score when a game ends, if it beats the best so far
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         go_prev_q <= 1'b1;
         hs_q      <= '0;
      end else begin
         go_prev_q <= go_q;
         if (go_q && !go_prev_q && score_q > hs_q) hs_q <= score_q;
      end
   end
   assign high_score = hs_q;
`else
   assign high_score = '0;
`endif
   assign score_bcd    = score_q;
   assign lives        = lives_q;
   assign game_over    = go_q;
   assign extra_life   = award_ok && !game_begin;
   assign busy         = st_q != SL_IDLE;
   assign pts_overflow = ovf_q;
endmodule
